// File: rtl/fmm_me_read_arbiter.sv
// ============================================================================
// Module   : fmm_me_read_arbiter
// Brief    : Round-robin arbiter sharing the M_e pivot-flag read port between
//            NUM_REQ scan engines; returns tagged 2-cycle-latency responses.
//            Optional macro FMM_ME_ARB_PERF_CNT_EN adds per-engine grant counters.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fmm_me_read_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int ROW_STRIDE = 320
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      arb_en,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*31-1:0]     req_row,
    input  logic [NUM_REQ*ADDR_W-1:0] req_col,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [ADDR_W-1:0]         M_e_address0,
    output logic                      M_e_ce0,
    input  logic [DATA_W-1:0]         M_e_q0,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      rsp_match
`ifdef FMM_ME_ARB_PERF_CNT_EN
    ,
    input  logic                      perf_clr,
    output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [PTR_W:0]       c_num_req  = (PTR_W+1)'(NUM_REQ);
    localparam logic [PTR_W-1:0]     c_last_idx = PTR_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]   c_one_hot0 = NUM_REQ'(1);
    localparam logic [DATA_W-1:0]    c_data_one = DATA_W'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [PTR_W-1:0]   rr_ptr_q;
    logic [PTR_W-1:0]   rr_ptr_d;
    logic               pend_q;
    logic [PTR_W-1:0]   tag_q;
    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [NUM_REQ-1:0] rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q;
    logic               rsp_match_q;
    logic               rsp_match_d;

    // ------------------------------------------------------------------------
    // Rotating-priority search starting at rr_ptr_q
    // ------------------------------------------------------------------------
    logic               w_found;
    logic               w_grant;
    logic [PTR_W-1:0]   w_grant_idx;
    logic [PTR_W:0]     w_scan_sum;
    logic [PTR_W-1:0]   w_scan_idx;

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_scan_sum  = '0;
        w_scan_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scan_sum = {1'b0, rr_ptr_q} + k[PTR_W:0];
            if (w_scan_sum >= c_num_req) begin
                w_scan_sum = w_scan_sum - c_num_req;
            end
            w_scan_idx = w_scan_sum[PTR_W-1:0];
            if (!w_found && req_valid[w_scan_idx]) begin
                w_found     = 1'b1;
                w_grant_idx = w_scan_idx;
            end
        end
    end

    // Gated by the reset level so ready/ce read 0 throughout reset.
    assign w_grant = w_found & arb_en & ap_rst_n;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_grant) begin
            rr_ptr_d = (w_grant_idx == c_last_idx) ? '0 : w_grant_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Address generation: row*ROW_STRIDE + col, modulo 2^ADDR_W
    // ------------------------------------------------------------------------
    logic [30:0]       w_row_sel;
    logic [ADDR_W-1:0] w_row_a;
    logic [ADDR_W-1:0] w_col_a;
    logic [ADDR_W-1:0] w_addr_full;

    assign w_row_sel = req_row[31*w_grant_idx +: 31];
    assign w_col_a   = req_col[ADDR_W*w_grant_idx +: ADDR_W];

    generate
        if (ADDR_W <= 31) begin : g_row_narrow
            assign w_row_a = w_row_sel[ADDR_W-1:0];
        end else begin : g_row_wide
            assign w_row_a = {{(ADDR_W-31){1'b0}}, w_row_sel};
        end

        if (ROW_STRIDE == 320) begin : g_stride_shift
            assign w_addr_full = (w_row_a << 8) + (w_row_a << 6) + w_col_a;
        end else begin : g_stride_mult
            localparam logic [ADDR_W-1:0] c_stride = ADDR_W'(ROW_STRIDE);
            assign w_addr_full = (w_row_a * c_stride) + w_col_a;
        end
    endgenerate

    assign req_ready    = w_grant ? (c_one_hot0 << w_grant_idx) : '0;
    assign M_e_ce0      = w_grant;
    assign M_e_address0 = w_grant ? w_addr_full : '0;

    // ------------------------------------------------------------------------
    // Response path: read data arrives the cycle after the grant and is
    // registered together with the engine tag captured at grant time.
    // ------------------------------------------------------------------------
    assign rsp_valid_d = pend_q ? (c_one_hot0 << tag_q) : '0;
    assign rsp_match_d = (M_e_q0 == c_data_one);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rr_ptr_q    <= '0;
            pend_q      <= 1'b0;
            tag_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_match_q <= 1'b0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            pend_q      <= w_grant;
            tag_q       <= w_grant_idx;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= M_e_q0;
            rsp_match_q <= rsp_match_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_match = rsp_match_q;

    // ------------------------------------------------------------------------
    // Optional saturating grant counters
    // ------------------------------------------------------------------------
`ifdef FMM_ME_ARB_PERF_CNT_EN
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_perf_cnt
            logic [15:0] cnt_q;
            logic [15:0] cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (perf_clr) begin
                    cnt_d = '0;
                end else if (req_ready[gi] && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge ap_clk or negedge ap_rst_n) begin
                if (!ap_rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign grant_cnt[16*gi +: 16] = cnt_q;
        end
    endgenerate
`endif

endmodule

`default_nettype wire
